// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: issue/launch/wait/writeback sequencer for an iterative mul/div unit.
// Optional build macro MULTDIV_CTRL_TIMEOUT_EN: abort a WAIT that reaches
// TIMEOUT_CYCLES without unit_rdy, writing back wb_data=0 / wb_exc=3'd6.
// Without the macro the wait counter runs but never aborts an op.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [4:0]  alu_opcode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  dest_reg,
  input  logic        flush,
  input  logic        unit_rdy,
  input  logic        unit_exc,
  input  logic [31:0] unit_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic [2:0]  wb_exc
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned EXC_W  = 3;
  localparam int unsigned CNT_W  = 8;

  localparam logic [OPC_W-1:0] OPC_MUL = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_DIV = 5'b00111;

  localparam logic [EXC_W-1:0] EXC_NONE    = 3'd0;
  localparam logic [EXC_W-1:0] EXC_MUL     = 3'd4;
  localparam logic [EXC_W-1:0] EXC_DIV     = 3'd5;
  localparam logic [EXC_W-1:0] EXC_TIMEOUT = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Counter reads N-1 during the Nth WAIT cycle, so abort on the limit minus one.
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 32'd1);

`ifdef MULTDIV_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               md_op_c;
  logic               accept_c;
  logic               capture_c;
  logic               timeout_c;
  logic               to_hit_c;
  logic               kind_mul_q;
  logic [REG_W-1:0]   dest_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               wb_pend_q;

  // Decode a mul/div issue.
  assign md_op_c = issue_valid && ((alu_opcode == OPC_MUL) || (alu_opcode == OPC_DIV));

  // Timeout only has an effect when the feature is compiled in.
  assign to_hit_c = TO_EN && (wait_cnt_q >= TO_LIMIT);

  // Hold upstream while busy or while accepting; forced low while in reset.
  assign stall = reset_n && ((state_q != S_IDLE) || (md_op_c && !flush));

  // Writeback strobe is killed by a flush arriving during DONE.
  assign wb_valid = wb_pend_q && !flush;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (md_op_c && !flush) begin
          state_d  = S_LAUNCH;
          accept_c = 1'b1;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (unit_rdy) begin
          state_d   = S_DONE;
          capture_c = 1'b1;
        end else if (to_hit_c) begin
          state_d   = S_DONE;
          timeout_c = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      accept_c  = 1'b0;
      capture_c = 1'b0;
      timeout_c = 1'b0;
    end
  end

  // Operand latch and start pulses, registered on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_mult  <= 1'b0;
      ctrl_div   <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
      kind_mul_q <= 1'b0;
      dest_q     <= '0;
    end else begin
      ctrl_mult <= accept_c && (alu_opcode == OPC_MUL);
      ctrl_div  <= accept_c && (alu_opcode == OPC_DIV);
      if (accept_c) begin
        unit_a     <= op_a;
        unit_b     <= op_b;
        kind_mul_q <= (alu_opcode == OPC_MUL);
        dest_q     <= dest_reg;
      end
    end
  end

  // Wait-cycle counter: cleared in LAUNCH, saturating count in WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      wait_cnt_q <= '0;
    end else if ((state_q == S_WAIT) && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // Writeback capture; the result is passed through untouched even with an exception.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_pend_q <= 1'b0;
      wb_data   <= '0;
      wb_reg    <= '0;
      wb_exc    <= '0;
    end else begin
      wb_pend_q <= capture_c || timeout_c;
      if (capture_c) begin
        wb_data <= unit_result;
        wb_reg  <= dest_q;
        wb_exc  <= unit_exc ? (kind_mul_q ? EXC_MUL : EXC_DIV) : EXC_NONE;
      end else if (timeout_c) begin
        wb_data <= DATA_W'(0);
        wb_reg  <= dest_q;
        wb_exc  <= EXC_TIMEOUT;
      end
    end
  end

endmodule
